// File: rtl/bcount_monitor_if.sv
// Count-stream bus between a count producer (master) and bcount_monitor (slave).
// Samples en/d in; lock, break and switching-activity results out.
interface bcount_monitor_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ERRW  = 16,
   parameter int unsigned TOGW  = 24
);
   logic             en;
   logic [WIDTH-1:0] d;
   logic             locked;
   logic             err;
   logic [ERRW-1:0]  err_count;
   logic [TOGW-1:0]  toggles;

   modport master (output en, d, input locked, err, err_count, toggles);
   modport slave  (input en, d, output locked, err, err_count, toggles);
endinterface

// File: rtl/bcount_monitor.sv
// Lock/break monitor for a +1 binary count stream, with optional switching-activity
// accumulator compiled in by defining TOGGLE_COUNT_EN.
module bcount_monitor #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned LOCK_N = 4,
   parameter int unsigned ERRW   = 16,
   parameter int unsigned TOGW   = 24
) (
   input logic             clk,
   input logic             reset,
   bcount_monitor_if.slave bus
);
   localparam int unsigned RUNW = $clog2(LOCK_N) + 1;

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [RUNW-1:0]  run_q, run_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [ERRW-1:0]  errc_q, errc_d;
   logic             inc_ok_c;

   // A repeated value fails this test, so it is treated as a break.
   assign inc_ok_c = (bus.d == prev_q + WIDTH'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= HUNT;
         prev_q   <= '0;
         run_q    <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         errc_q   <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         run_q    <= run_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         errc_q   <= errc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      prev_d  = prev_q;
      if (bus.en) begin
         prev_d = bus.d;
         unique case (state_q)
            HUNT: begin
               run_d   = '0;
               state_d = SYNC;
            end
            SYNC: begin
               if (!inc_ok_c) begin
                  run_d = '0;
               end else if (run_q == RUNW'(LOCK_N - 1)) begin
                  run_d   = '0;
                  state_d = LOCKED;
               end else begin
                  run_d = run_q + RUNW'(1);
               end
            end
            LOCKED: begin
               if (!inc_ok_c) begin
                  run_d   = '0;
                  state_d = SYNC;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Next values of the registered outputs; err clears on any non-break cycle.
   always_comb begin
      locked_d = (state_d == LOCKED);
      err_d    = 1'b0;
      errc_d   = errc_q;
      if (bus.en && (state_q == LOCKED) && !inc_ok_c) begin
         err_d = 1'b1;
         if (errc_q != '1) errc_d = errc_q + ERRW'(1);
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err       = err_q;
   assign bus.err_count = errc_q;

`ifdef TOGGLE_COUNT_EN
   localparam int unsigned POPW = $clog2(WIDTH + 1);
   localparam int unsigned SUMW = TOGW + 1;

   logic [TOGW-1:0] tog_q, tog_d;
   logic [POPW-1:0] pop_c;
   logic [SUMW-1:0] tog_sum_c;

   // Hamming distance to the previous sample, added with saturation.
   always_comb begin
      pop_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         pop_c = pop_c + POPW'(bus.d[i] ^ prev_q[i]);
      end
      tog_sum_c = {1'b0, tog_q} + SUMW'(pop_c);
      tog_d     = tog_q;
      if (bus.en && (state_q != HUNT)) begin
         tog_d = tog_sum_c[TOGW] ? '1 : tog_sum_c[TOGW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) tog_q <= '0;
      else       tog_q <= tog_d;
   end

   assign bus.toggles = tog_q;
`else
   assign bus.toggles = '0;
`endif
endmodule

// File: tb/tb_bcount_monitor.sv
// Randomized + directed bench for bcount_monitor against a streak-count reference model.
// Runs two instances sharing stimulus: ERRW=16 and ERRW=2 (for err_count saturation).
module tb_bcount_monitor;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned LOCK_N = 4;
   localparam int unsigned TOGW   = 24;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       en    = 1'b0;
   logic [7:0] d     = 8'h00;

   always #5 clk = ~clk;

   bcount_monitor_if #(.WIDTH(WIDTH), .ERRW(16), .TOGW(TOGW)) if_a ();
   bcount_monitor_if #(.WIDTH(WIDTH), .ERRW(2),  .TOGW(TOGW)) if_b ();

   assign if_a.en = en;
   assign if_a.d  = d;
   assign if_b.en = en;
   assign if_b.d  = d;

   bcount_monitor #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .ERRW(16), .TOGW(TOGW)) dut_a (
      .clk(clk), .reset(reset), .bus(if_a));
   bcount_monitor #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .ERRW(2), .TOGW(TOGW)) dut_b (
      .clk(clk), .reset(reset), .bus(if_b));

   int checks = 0;
   int errors = 0;

   // Reference model: locked means the current run of correct +1 steps is >= LOCK_N.
   bit         m_seeded;
   logic [7:0] m_prev;
   int         m_streak;
   bit         m_err;
   longint     m_errc_a, m_errc_b, m_tog;
   logic [7:0] cur;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint exp_toggles();
`ifdef TOGGLE_COUNT_EN
      return m_tog;
`else
      return 0;
`endif
   endfunction

   task automatic model_update(input logic r, input logic e, input logic [7:0] v);
      logic [7:0] nxt;
      if (r) begin
         m_seeded = 0; m_prev = 8'h00; m_streak = 0; m_err = 0;
         m_errc_a = 0; m_errc_b = 0; m_tog = 0;
         return;
      end
      m_err = 0;
      if (!e) return;
      if (!m_seeded) begin
         m_seeded = 1; m_streak = 0;
      end else begin
         nxt   = m_prev + 8'd1;
         m_tog = m_tog + $countones(v ^ m_prev);
         if (m_tog > 64'd16777215) m_tog = 64'd16777215;
         if (v == nxt) begin
            if (m_streak < int'(LOCK_N)) m_streak++;
         end else begin
            if (m_streak >= int'(LOCK_N)) begin
               m_err = 1;
               if (m_errc_a < 65535) m_errc_a++;
               if (m_errc_b < 3) m_errc_b++;
            end
            m_streak = 0;
         end
      end
      m_prev = v;
   endtask

   task automatic compare_all();
      check_val("locked_a", longint'(if_a.locked), longint'(m_streak >= int'(LOCK_N)));
      check_val("locked_b", longint'(if_b.locked), longint'(m_streak >= int'(LOCK_N)));
      check_val("err_a", longint'(if_a.err), longint'(m_err));
      check_val("err_b", longint'(if_b.err), longint'(m_err));
      check_val("err_count_a", longint'(if_a.err_count), m_errc_a);
      check_val("err_count_b", longint'(if_b.err_count), m_errc_b);
      check_val("toggles_a", longint'(if_a.toggles), exp_toggles());
   endtask

   // Drive one cycle, advance the model at the edge, compare 1 time unit later.
   task automatic step(input logic r, input logic e, input logic [7:0] v);
      reset = r; en = e; d = v;
      if (e && !r) cur = v;
      @(posedge clk);
      model_update(r, e, v);
      #1;
      compare_all();
   endtask

   task automatic run_to(input logic [7:0] first, input logic [7:0] last);
      logic [7:0] v;
      v = first;
      forever begin
         step(1'b0, 1'b1, v);
         if (v == last) break;
         v = v + 8'd1;
      end
   endtask

   initial begin
      longint tog0;
      int     r;
      logic   e;
      logic [7:0] v;
      cur = 8'h00;

      repeat (3) step(1'b1, 1'b0, 8'h00);
      check_val("rst_locked", longint'(if_a.locked), 0);
      check_val("rst_err_count", longint'(if_a.err_count), 0);

      run_to(8'h00, 8'h03);
      check_val("not_locked_yet", longint'(if_a.locked), 0);
`ifdef TOGGLE_COUNT_EN
      check_val("tog_00_03", longint'(if_a.toggles), 4);
`endif
      step(1'b0, 1'b1, 8'h04);
      check_val("lock_after_04", longint'(if_a.locked), 1);

      run_to(8'h05, 8'h01);
      check_val("wrap_locked", longint'(if_a.locked), 1);
      check_val("wrap_no_err", longint'(if_a.err_count), 0);

      run_to(8'h02, 8'h11);
      step(1'b0, 1'b1, 8'h13);
      check_val("break_err", longint'(if_a.err), 1);
      check_val("break_count", longint'(if_a.err_count), 1);
      check_val("break_unlock", longint'(if_a.locked), 0);
      step(1'b0, 1'b1, 8'h14);
      check_val("err_one_cycle", longint'(if_a.err), 0);
      run_to(8'h15, 8'h17);
      check_val("relock_17", longint'(if_a.locked), 1);

      // Sparse enable with junk on d while en=0.
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 8'($urandom));
         step(1'b0, 1'b1, cur + 8'd1);
      end
      check_val("sparse_en_locked", longint'(if_a.locked), 1);

      // Full wrap pass: 256 increments.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      tog0 = longint'(if_a.toggles);
      run_to(8'h01, 8'h00);
`ifdef TOGGLE_COUNT_EN
      check_val("tog_full_pass", longint'(if_a.toggles) - tog0, 510);
`else
      check_val("tog_absent", longint'(if_a.toggles), 0);
`endif

      // Reset while locked, then reacquire.
      step(1'b1, 1'b1, 8'h01);
      check_val("rst_mid_locked", longint'(if_a.locked), 0);
      check_val("rst_mid_errc", longint'(if_a.err_count), 0);
      check_val("rst_mid_tog", longint'(if_a.toggles), 0);
      run_to(8'h20, 8'h23);
      check_val("relock_not_23", longint'(if_a.locked), 0);
      step(1'b0, 1'b1, 8'h24);
      check_val("relock_24", longint'(if_a.locked), 1);

      // Five breaks from LOCKED saturate the 2-bit counter.
      for (int k = 0; k < 5; k++) begin
         repeat (LOCK_N + 1) step(1'b0, 1'b1, cur + 8'd1);
         step(1'b0, 1'b1, cur);
      end
      check_val("sat_errc_b", longint'(if_b.err_count), 3);
      check_val("sat_errc_a", longint'(if_a.err_count), 5);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         e = ($urandom_range(0, 99) < 85);
         if (r < 75)      v = cur + 8'd1;
         else if (r < 85) v = cur;
         else             v = 8'($urandom);
         step(($urandom_range(0, 199) == 0), e, v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
